// File: rtl/menu_overlay_renderer.sv
// Menu-screen pixel classifier for the Snake VGA front end: title, option boxes with digits,
// flashing cursor and prompt, plus the left/right/confirm difficulty selection machine.
module menu_overlay_renderer #(
   parameter int X_W          = 8,
   parameter int Y_W          = 7,
   parameter int NUM_OPTIONS  = 3,
   parameter int OPT_X0       = 28,
   parameter int OPT_PITCH    = 45,
   parameter int OPT_Y0       = 64,
   parameter int BOX_W        = 16,
   parameter int BOX_H        = 15,
   parameter int PROMPT_Y0    = 104,
   parameter int FLASH_PERIOD = 50000000,
   parameter int FLASH_ON     = 25000000,
   parameter int WRAP         = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           inmenu,
   input  logic [X_W-1:0] x_pointer,
   input  logic [Y_W-1:0] y_pointer,
   input  logic           key_left,
   input  logic           key_right,
   input  logic           key_confirm,
   output logic           menu_text,
   output logic           menu_flash,
   output logic [1:0]     selected_level,
   output logic           level_valid
);

   localparam int CNT_W = (FLASH_PERIOD > 2) ? $clog2(FLASH_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLASH_PERIOD - 1);
   localparam logic [1:0] LAST_OPT = 2'(NUM_OPTIONS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MENU = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // 5x9 digit glyphs "1".."4", row 0 in the MSBs, leftmost column first.
   localparam logic [44:0] GLYPH [4] = '{
      45'b00110_01110_00110_00110_00110_00110_00110_00110_01111,
      45'b01110_10001_00001_00010_00100_01000_10000_10000_11111,
      45'b11110_00001_00001_00001_01110_00001_00001_00001_11110,
      45'b00010_00110_01010_10010_11111_00010_00010_00010_00010
   };

   logic [1:0]       state, state_nx;
   logic [1:0]       sel_nx;
   logic             valid_nx;
   logic             key_left_d, key_right_d, key_confirm_d;
   logic             rise_left, rise_right, rise_confirm;
   logic [CNT_W-1:0] flash_cnt;
   logic             flash_on;

   assign rise_left    = key_left & ~key_left_d;
   assign rise_right   = key_right & ~key_right_d;
   assign rise_confirm = key_confirm & ~key_confirm_d;
   assign flash_on     = int'(flash_cnt) < FLASH_ON;

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      state_nx = state;
      sel_nx   = selected_level;
      valid_nx = 1'b0;
      if (!inmenu) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE: state_nx = S_MENU;
            S_MENU: begin
               if (rise_confirm) begin
                  valid_nx = 1'b1;
                  state_nx = S_DONE;
               end else if (rise_right && !rise_left) begin
                  if (selected_level == LAST_OPT) sel_nx = (WRAP != 0) ? 2'd0 : selected_level;
                  else                            sel_nx = selected_level + 2'd1;
               end else if (rise_left && !rise_right) begin
                  if (selected_level == 2'd0) sel_nx = (WRAP != 0) ? LAST_OPT : selected_level;
                  else                        sel_nx = selected_level - 2'd1;
               end
            end
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         selected_level <= 2'd0;
         level_valid    <= 1'b0;
         flash_cnt      <= CNT_MAX;
         key_left_d     <= 1'b0;
         key_right_d    <= 1'b0;
         key_confirm_d  <= 1'b0;
      end else begin
         state          <= state_nx;
         selected_level <= sel_nx;
         level_valid    <= valid_nx;
         key_left_d     <= key_left;
         key_right_d    <= key_right;
         key_confirm_d  <= key_confirm;
         // A freshly moved cursor always starts in the off phase.
         if (sel_nx != selected_level || flash_cnt == '0) flash_cnt <= CNT_MAX;
         else                                             flash_cnt <= flash_cnt - CNT_W'(1);
      end
   end

   function automatic logic rect(input int lx, input int ly,
                                 input int x0, input int x1, input int y0, input int y1);
      return (lx >= x0) && (lx <= x1) && (ly >= y0) && (ly <= y1);
   endfunction

   // Letter k of "SNAKE" in a 25x45 cell with 6-pixel strokes.
   function automatic logic letter_pixel(input int k, input int lx, input int ly);
      logic hit;
      hit = rect(lx, ly, 0, 5, 0, 44);
      case (k)
         0: hit = rect(lx, ly, 0, 24, 0, 5) | rect(lx, ly, 0, 5, 0, 24) | rect(lx, ly, 0, 24, 19, 24)
                | rect(lx, ly, 19, 24, 19, 44) | rect(lx, ly, 0, 24, 39, 44);
         1: hit = hit | rect(lx, ly, 19, 24, 0, 44) | rect(lx, ly, 6, 18, 13, 30);
         2: hit = hit | rect(lx, ly, 19, 24, 0, 44) | rect(lx, ly, 0, 24, 0, 5) | rect(lx, ly, 0, 24, 19, 24);
         3: hit = hit | rect(lx, ly, 6, 18, 16, 28) | rect(lx, ly, 19, 24, 0, 15) | rect(lx, ly, 19, 24, 29, 44);
         default: hit = hit | rect(lx, ly, 0, 24, 0, 5) | rect(lx, ly, 0, 24, 19, 24) | rect(lx, ly, 0, 24, 39, 44);
      endcase
      return hit;
   endfunction

   function automatic logic title_hit(input int x, input int y);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 5; k++) hit = hit | letter_pixel(k, x - (10 + 29 * k), y - 10);
      return hit;
   endfunction

   logic [X_W:0] px;
   logic [Y_W:0] py;
   logic [3:0]   outline_v, inner_v, glyph_v;
   logic         in_title, in_prompt, text_hit, sel_inner, sel_glyph, active;
   logic         flash_raw, text_nx, flash_nx;

   assign px        = {1'b0, x_pointer};
   assign py        = {1'b0, y_pointer};
   assign in_title  = title_hit(int'(x_pointer), int'(y_pointer));
   assign in_prompt = px >= (X_W+1)'(45) && px <= (X_W+1)'(112) &&
                      py >= (Y_W+1)'(PROMPT_Y0) && py <= (Y_W+1)'(PROMPT_Y0 + 7);

   always_comb begin
      logic [X_W:0] bx0, bx1, gx0;
      logic [Y_W:0] by0, by1, gy0;
      logic [1:0]   idx;
      logic         in_box, on_edge, in_cell;
      outline_v = '0;
      inner_v   = '0;
      glyph_v   = '0;
      for (int i = 0; i < 4; i++) begin
         idx     = 2'(i);
         bx0     = (X_W+1)'(OPT_X0 + i * OPT_PITCH);
         bx1     = bx0 + (X_W+1)'(BOX_W - 1);
         by0     = (Y_W+1)'(OPT_Y0);
         by1     = by0 + (Y_W+1)'(BOX_H - 1);
         gx0     = bx0 + (X_W+1)'((BOX_W - 4) / 2);
         gy0     = by0 + (Y_W+1)'((BOX_H - 9) / 2);
         in_box  = (i < NUM_OPTIONS) && px >= bx0 && px <= bx1 && py >= by0 && py <= by1;
         on_edge = px == bx0 || px == bx1 || py == by0 || py == by1;
         in_cell = px >= gx0 && px <= gx0 + (X_W+1)'(4) && py >= gy0 && py <= gy0 + (Y_W+1)'(8);
         outline_v[idx] = in_box && on_edge;
         inner_v[idx]   = in_box && !on_edge;
         if (in_box && in_cell)
            glyph_v[idx] = GLYPH[idx][6'(44 - 5 * int'(py - gy0) - int'(px - gx0))];
      end
   end

   assign text_hit  = in_title || (|outline_v) || (|glyph_v);
   assign sel_inner = inner_v[selected_level];
   assign sel_glyph = glyph_v[selected_level];
   assign active    = inmenu && (state != S_IDLE);
   // After confirm the cursor turns solid and the prompt disappears.
   assign flash_raw = (state == S_DONE) ? sel_inner
                                        : flash_on && ((sel_inner && !sel_glyph) || in_prompt);
   assign text_nx   = active && text_hit;
   assign flash_nx  = active && !text_hit && flash_raw;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         menu_text  <= 1'b0;
         menu_flash <= 1'b0;
      end else begin
         menu_text  <= text_nx;
         menu_flash <= flash_nx;
      end
   end

endmodule
